// File: rtl/pe_result_drain.sv
// Snapshots N accumulator results on a capture strobe and streams them out, index 0 first.
// Latency: first word valid 1 cycle after capture; N words in N cycles with ready held high.
// Backpressure: i_ready low holds data/idx stable; a capture that would disturb a drain is dropped and flagged.
module pe_result_drain #(
    parameter  int W  = 32,
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_capture,
    input  logic [N*2*W-1:0] i_C,
    input  logic             i_ready,
    input  logic             i_clr_overrun,
    output logic             o_valid,
    output logic [2*W-1:0]   o_data,
    output logic [IW-1:0]    o_idx,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [2*W-1:0]   shadow_q [N];
    logic [2*W-1:0]   shadow_d [N];
    logic             overrun_q, overrun_d;

    logic             at_last;
    logic             xfer;
    logic             load;
    logic             drop;

    // The word on the output is the last of the tile.
    assign at_last = (idx_q == IW'(N - 1));
    // A handshake completes this cycle.
    assign xfer    = (state_q == DRAIN) && i_ready;

    // Next-state logic: capture acceptance, index advance and the sticky overrun flag.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        drop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_capture) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && at_last) begin
                    // Final word leaves this cycle, so a coincident capture
                    // can reload without a bubble.
                    idx_d = '0;
                    if (i_capture) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + IW'(1);
                    end
                    // Any other capture would corrupt the tile in flight.
                    if (i_capture) begin
                        drop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            for (int k = 0; k < N; k++) begin
                shadow_d[k] = i_C[k*2*W +: 2*W];
            end
        end

        // A drop takes priority over a clear in the same cycle.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // State, index, snapshot and overrun registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
        end
    end

    // Outputs are driven straight from registered state.
    assign o_valid   = (state_q == DRAIN);
    assign o_busy    = (state_q == DRAIN);
    assign o_data    = shadow_q[idx_q];
    assign o_idx     = idx_q;
    assign o_last    = (state_q == DRAIN) && at_last;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: directed scenarios plus random traffic.
// Expected words are queued at capture time; a negedge monitor pops and compares on each handshake.
// Per-cycle status (valid/busy/overrun) is checked against a word-count model after every edge.
module tb_pe_result_drain;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic             i_clk;
    logic             i_rst;
    logic             i_capture;
    logic [N*2*W-1:0] i_C;
    logic             i_ready;
    logic             i_clr_overrun;
    logic             o_valid;
    logic [2*W-1:0]   o_data;
    logic [IW-1:0]    o_idx;
    logic             o_last;
    logic             o_busy;
    logic             o_overrun;

    pe_result_drain #(.W(W), .N(N)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_capture     (i_capture),
        .i_C           (i_C),
        .i_ready       (i_ready),
        .i_clr_overrun (i_clr_overrun),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_idx         (o_idx),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int          idx;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          tests  = 0;
    int          fails  = 0;
    int          pending = 0;   // words of accepted tiles not yet handed over
    bit          ovr_m  = 1'b0; // expected overrun flag
    logic [63:0] tile [N];      // words to present on the next capture

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_tile_rand();
        for (int k = 0; k < N; k++) tile[k] = {$urandom, $urandom};
    endtask

    // One clock cycle: drive inputs, advance the model, then check status after the edge.
    task automatic step(input bit cap, input bit rdy, input bit clr, input bit rst);
        int remaining;
        i_capture     = cap;
        i_ready       = rdy;
        i_clr_overrun = clr;
        i_rst         = rst;
        for (int k = 0; k < N; k++)
            i_C[k*2*W +: 2*W] = cap ? tile[k] : {$urandom, $urandom};

        if (rst) begin
            pending = 0;
            exp_q.delete();
            ovr_m = 1'b0;
        end else begin
            remaining = (pending > 0 && rdy) ? pending - 1 : pending;
            if (cap && remaining == 0) begin
                for (int k = 0; k < N; k++) begin
                    exp_t e;
                    e.idx  = k;
                    e.data = tile[k];
                    exp_q.push_back(e);
                end
                pending = remaining + N;
            end else begin
                pending = remaining;
            end
            if (cap && remaining != 0) ovr_m = 1'b1;
            else if (clr)              ovr_m = 1'b0;
        end

        @(posedge i_clk);
        #1;
        chk("valid", 64'(o_valid), 64'(pending > 0));
        chk("busy", 64'(o_busy), 64'(pending > 0));
        chk("overrun", 64'(o_overrun), 64'(ovr_m));
        if (pending == 0) chk("last_idle", 64'(o_last), 64'd0);
        if (rst) begin
            chk("rst_data", o_data, 64'd0);
            chk("rst_idx", 64'(o_idx), 64'd0);
        end
    endtask

    // Scoreboard monitor: every presented word must match the queue head.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(o_idx), 64'hFFFF);
                end else begin
                    chk("data", o_data, exp_q[0].data);
                    chk("idx", 64'(o_idx), 64'(exp_q[0].idx));
                    chk("last", 64'(o_last), 64'(exp_q[0].idx == N - 1));
                    if (i_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drain_all();
        for (int i = 0; i < 40 && pending > 0; i++) step(0, 1, 0, 0);
        chk("drained", 64'(pending), 64'd0);
    endtask

    initial begin
        bit rp [7];
        i_rst = 1'b1; i_capture = 1'b0; i_C = '0; i_ready = 1'b0; i_clr_overrun = 1'b0;
        for (int k = 0; k < N; k++) tile[k] = '0;

        // Reset
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);

        // Idle hygiene: ready toggles, no capture
        for (int i = 0; i < 20; i++) step(0, i[0], 0, 0);

        // Basic drain
        tile[0] = 64'h1; tile[1] = 64'h2;
        tile[2] = 64'hFFFF_FFFF_FFFF_FFFF; tile[3] = 64'h8000_0000_0000_0000;
        step(1, 1, 0, 0);
        for (int i = 0; i < N; i++) step(0, 1, 0, 0);
        chk("basic_idle", 64'(pending), 64'd0);

        // Backpressure; i_C keeps changing randomly every cycle
        step(1, 0, 0, 0);
        rp = '{1, 0, 0, 1, 0, 1, 1};
        for (int i = 0; i < 7; i++) step(0, rp[i], 0, 0);
        drain_all();

        // Back-to-back tiles
        set_tile_rand();
        step(1, 1, 0, 0);
        while (pending > 1) step(0, 1, 0, 0);
        for (int k = 0; k < N; k++) tile[k] = 64'h10 + 64'(k);
        step(1, 1, 0, 0);
        chk("b2b_idx0", 64'(o_idx), 64'd0);
        chk("b2b_data0", o_data, 64'h10);
        drain_all();

        // Overrun: drop at idx 1 with ready low, then clear, then drop+clear
        set_tile_rand();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("ovr_at_idx1", 64'(o_idx), 64'd1);
        set_tile_rand();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        drain_all();
        step(0, 0, 1, 0);

        // Reset mid-drain at idx 2, then fresh capture
        set_tile_rand();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("rst_at_idx2", 64'(o_idx), 64'd2);
        step(0, 1, 0, 1);
        set_tile_rand();
        step(1, 1, 0, 0);
        chk("fresh_idx0", 64'(o_idx), 64'd0);
        drain_all();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) set_tile_rand();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
        end
        drain_all();
        step(0, 0, 0, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Read side of the PE accumulator interface; instantiated once per systolic-array column.
- On a capture strobe it snapshots the 2W-bit accumulator results of N PEs in parallel into shadow registers. The strobe is issued alongside the PE sync/reload pulse, the same cycle the PEs reload.
- It then serialises the snapshot out over a valid/ready stream, index 0 first, while the PEs accumulate the next tile.

Parameters:
- W, 32: PE operand width; each result word is 2*W bits.
- N, 4: number of PE results per column; must be >= 2.
- IW, $clog2(N): index width, derived; not overridden.

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_capture  in  1  snapshot strobe, one cycle wide, aligned with PE i_sync.
- i_C  in  N*2*W  flattened PE results; PE k occupies bits [k*2W +: 2W].
- i_ready  in  1  downstream ready.
- i_clr_overrun  in  1  clears the sticky overrun flag.
- o_valid  out  1  o_data holds a valid word.
- o_data  out  2*W  current result word.
- o_idx  out  IW  PE index of o_data.
- o_last  out  1  high with o_valid when o_idx == N-1.
- o_busy  out  1  high while in the DRAIN state.
- o_overrun  out  1  sticky; set when a capture is dropped.

Behaviour:
- Reset (sync, i_rst=1 at an edge):
  - State goes to IDLE.
  - o_valid, o_last, o_busy, o_overrun go to 0; o_data, o_idx and all shadow registers go to 0.
  - Reset wins over every other input, including mid-drain; the in-flight snapshot is discarded.
- FSM states: IDLE, DRAIN.
- IDLE:
  - i_capture=1 latches all N words of i_C into shadow registers, sets idx=0, and moves to DRAIN.
  - The cycle after capture: o_valid=1, o_data=shadow[0], o_busy=1. Latency from capture to first valid is 1 cycle.
- DRAIN:
  - o_valid=1 continuously. o_data=shadow[idx], o_idx=idx, o_last=(idx==N-1).
  - Transfer occurs when o_valid && i_ready at an edge.
  - Transfer with idx<N-1: idx increments.
  - Transfer with idx==N-1: go to IDLE; o_valid, o_busy, o_last drop next cycle.
  - With i_ready=0, o_data, o_idx and o_last hold stable. There is no timeout.
- Capture during DRAIN:
  - Coincident with the final transfer (idx==N-1, i_ready=1): accepted. Shadow is reloaded, idx=0, state stays DRAIN, o_valid stays 1. This gives back-to-back tiles with no bubble.
  - Otherwise: dropped. Shadow and idx are untouched and o_overrun is set to 1 next cycle.
- Overrun flag:
  - o_overrun is cleared by i_clr_overrun=1 at an edge.
  - If a drop and i_clr_overrun=1 occur in the same cycle, set wins and o_overrun stays 1.
- Data path:
  - No arithmetic; words are passed bit-exact and unsigned.
  - Shadow registers are written only on an accepted capture, so later i_C changes never disturb a drain in progress.
- Throughput: with i_ready held high, N words in N cycles. The minimum capture period for loss-free operation is N cycles.

Test Plan:
- Basic drain:
  - Stimulus: W=32, N=4. i_C words = {0x1, 0x2, 0xFFFF_FFFF_FFFF_FFFF, 0x8000_0000_0000_0000} for idx 0..3. Pulse i_capture, i_ready=1.
  - Required: o_valid for 4 consecutive cycles starting 1 cycle after capture. o_idx runs 0..3 with matching data. o_last only on idx 3. o_busy falls after idx 3.
- Backpressure:
  - Stimulus: same capture, i_ready toggling 1,0,0,1,0,1,1.
  - Required: o_data/o_idx stable through every stall. Exactly 4 transfers, in order. Change i_C mid-drain; the emitted data must not change.
- Back-to-back tiles:
  - Stimulus: second capture (values 0x10..0x13) pulsed on the cycle of the idx-3 transfer.
  - Required: o_valid never drops. Next cycle shows idx 0 = 0x10. o_overrun stays 0.
- Overrun:
  - Stimulus: second capture while idx=1 and i_ready=0.
  - Required: first tile drains unchanged, o_overrun=1 next cycle and stays 1. i_clr_overrun clears it. A drop plus clear in the same cycle leaves o_overrun at 1.
- Reset mid-drain:
  - Stimulus: assert i_rst at idx=2.
  - Required: next cycle all outputs are 0 and state is IDLE. A fresh capture after reset restarts at idx 0 with the new data.
- Idle hygiene:
  - Stimulus: i_ready toggling, no capture, for 20 cycles after reset.
  - Required: o_valid=0 and o_busy=0 throughout.
